// File: rtl/vball_bg_render.sv
// Background tilemap renderer: fetches one 8x8 4bpp tile every 8 pixel clocks from
// map VRAM and tile ROM, applies latched X/Y scroll and per-tile hflip, emits a colour index.
module vball_bg_render #(
    parameter int HTOTAL   = 400,
    parameter int VLAST    = 258,
    parameter int PREFETCH = 384
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [8:0]  hcount,
    input  logic [8:0]  vcount,
    input  logic        hb,
    input  logic        vb,
    input  logic        bg_en,
    input  logic [8:0]  scrollx,
    input  logic [7:0]  scrolly,
    output logic [10:0] vram_addr,
    input  logic [15:0] vram_data,
    output logic [16:0] rom_addr,
    input  logic [7:0]  rom_data,
    output logic [6:0]  pix,
    output logic        pix_opaque
);

    localparam logic signed [9:0] HTOT_S = 10'(HTOTAL);

    logic [8:0]  sx_lat;
    logic [7:0]  sy_lat;

    logic [11:0] code_p1;
    logic [2:0]  pal_p1;
    logic        flip_p1;
    logic [7:0]  byte0_p1, byte1_p1, byte2_p1;

    logic [31:0] shift_p2;
    logic [2:0]  pal_p2;
    logic        flip_p2;

    logic              pre_p0;
    logic signed [9:0] d_p0;
    logic [8:0]        line_p0;
    logic [8:0]        sx_p0;
    logic [7:0]        sy_p0;
    logic [5:0]        col_p0;
    logic [2:0]        phase_p0;
    logic [3:0]        nib_p0;
    logic              vld_p0;

    // Nibble idx 0 is the high nibble of the first tile byte (leftmost pixel).
    function automatic logic [3:0] pick_nibble(input logic [31:0] s, input logic [2:0] idx);
        logic [4:0] lsb;
        lsb = 5'd28 - {idx, 2'b00};
        return s[lsb +: 4];
    endfunction

    // Stage p0: line-relative position; the prefetch window runs at negative d on the next line
    assign pre_p0   = (hcount >= 9'(PREFETCH));
    assign d_p0     = pre_p0 ? ($signed({1'b0, hcount}) - HTOT_S) : $signed({1'b0, hcount});
    assign line_p0  = pre_p0 ? ((vcount == 9'(VLAST)) ? 9'd0 : vcount + 9'd1) : vcount;
    assign sx_p0    = 9'(d_p0 + $signed({1'b0, sx_lat}));
    assign sy_p0    = 8'(line_p0 + {1'b0, sy_lat});
    assign phase_p0 = sx_p0[2:0];
    // (sx + 8) >> 3 == (sx >> 3) + 1 modulo the 64-column map
    assign col_p0   = sx_p0[8:3] + 6'd1;
    assign nib_p0   = pick_nibble(shift_p2, flip_p2 ? ~phase_p0 : phase_p0);
    assign vld_p0   = !(hb || vb) && bg_en;

    // Stage p1: tile fetch pipeline; Stage p2: shifter load and registered output
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sx_lat     <= '0;
            sy_lat     <= '0;
            vram_addr  <= '0;
            rom_addr   <= '0;
            code_p1    <= '0;
            pal_p1     <= '0;
            flip_p1    <= 1'b0;
            byte0_p1   <= '0;
            byte1_p1   <= '0;
            byte2_p1   <= '0;
            shift_p2   <= '0;
            pal_p2     <= '0;
            flip_p2    <= 1'b0;
            pix        <= '0;
            pix_opaque <= 1'b0;
        end else begin
            if (hcount == 9'(PREFETCH - 1)) begin
                sx_lat <= scrollx;
                sy_lat <= scrolly;
            end
            case (phase_p0)
                3'd0: vram_addr <= {sy_p0[7:3], col_p0};
                3'd2: begin
                    code_p1  <= vram_data[11:0];
                    pal_p1   <= vram_data[14:12];
                    flip_p1  <= vram_data[15];
                    rom_addr <= {vram_data[11:0], sy_p0[2:0], 2'd0};
                end
                3'd3: rom_addr <= {code_p1, sy_p0[2:0], 2'd1};
                3'd4: begin
                    rom_addr <= {code_p1, sy_p0[2:0], 2'd2};
                    byte0_p1 <= rom_data;
                end
                3'd5: begin
                    rom_addr <= {code_p1, sy_p0[2:0], 2'd3};
                    byte1_p1 <= rom_data;
                end
                3'd6: byte2_p1 <= rom_data;
                default: begin
                    shift_p2 <= {byte0_p1, byte1_p1, byte2_p1, rom_data};
                    pal_p2   <= pal_p1;
                    flip_p2  <= flip_p1;
                end
            endcase
            pix        <= vld_p0 ? {pal_p2, nib_p0} : 7'd0;
            pix_opaque <= vld_p0 && (nib_p0 != 4'd0);
        end
    end

endmodule
